// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic              neg;
  logic [XLEN-1:0]   b;
  logic [2*XLEN-1:0] p;
  logic [CW-1:0]     cnt;
  logic              s1, s2, n1, n2, div0, ovf, neg_in;
  logic [XLEN-1:0]   ma, mb, fast_data, dsel, res;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] p_mul, p_div, pn;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign wb_valid  = state == DONE;
  always_comb begin
    s1        = req_op[2] ? ~req_op[0] : (req_op[1:0] != 2'b11);
    s2        = req_op[2] ? ~req_op[0] : ~req_op[1];
    n1        = s1 & req_rs1[XLEN-1];
    n2        = s2 & req_rs2[XLEN-1];
    ma        = n1 ? -req_rs1 : req_rs1;
    mb        = n2 ? -req_rs2 : req_rs2;
    neg_in    = (req_op[2] & req_op[1]) ? n1 : n1 ^ n2;
    div0      = req_op[2] & (req_rs2 == '0);
    ovf       = req_op[2] & ~req_op[0] & (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&req_rs2);
    fast_data = div0 ? (req_op[1] ? req_rs1 : '1) : (req_op[1] ? '0 : req_rs1);
    // p holds {partial product, multiplier} or {remainder, dividend/quotient}
    sum       = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b} : '0);
    p_mul     = {sum, p[XLEN-1:1]};
    shifted   = p[2*XLEN-1:XLEN-1];
    diff      = shifted - {1'b0, b};
    p_div     = {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0], p[XLEN-2:0], ~diff[XLEN]};
    pn        = neg ? -p : p;
    dsel      = op[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    res       = op[2] ? (neg ? -dsel : dsel) : (op[1:0] == 2'b00 ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op  <= req_op;
          rd  <= req_rd;
          neg <= neg_in;
          b   <= mb;
          p   <= {{XLEN{1'b0}}, ma};
          cnt <= CW'(XLEN - 1);
          if (div0 || ovf) begin
            wb_rd   <= req_rd;
            wb_data <= fast_data;
            state   <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          p     <= op[2] ? p_div : p_mul;
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : CALC;
          if (cnt == '0) cnt <= '0;
        end
        FIX: begin
          wb_rd   <= rd;
          wb_data <= res;
          state   <= DONE;
        end
        DONE: if (wb_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by an independent monitor
module tb_muldiv_unit;
  logic        clk = 0, reset = 1, req_valid = 0, wb_ready = 1;
  logic        req_ready, wb_valid, busy;
  logic [2:0]  req_op = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, wb_data;
  logic [4:0]  req_rd = 0, wb_rd;
  typedef struct {logic [4:0] rd; logic [31:0] data; int lat; int acc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, ecnt = 0;
  bit seen = 0;
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endfunction
  always @(negedge clk) if (!reset && wb_valid) begin
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_wb got rd %0d data %h expected none", wb_rd, wb_data);
    end else begin
      chk("wb_rd", {27'b0, wb_rd}, {27'b0, q[0].rd});
      chk("wb_data", wb_data, q[0].data);
      chk("req_ready_in_done", {31'b0, req_ready}, 32'd0);
      chk("busy_in_done", {31'b0, busy}, 32'd1);
      if (!seen) chk("latency", ecnt - q[0].acc + 1, q[0].lat);
      seen = 1;
    end
  end
  always @(posedge clk) if (!reset && wb_valid && wb_ready && q.size() > 0) begin
    void'(q.pop_front());
    seen = 0;
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got 0 expected 1");
    end
    #1 req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(posedge clk);
    #1;
    e.rd = rd; e.data = exp; e.lat = lat; e.acc = ecnt;
    q.push_back(e);
    req_valid = 0; req_rs1 = $urandom; req_rs2 = $urandom; req_op = 3'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    issue(3'b000, 32'd7, 32'd6, 5'd7, 32'd42, 34);
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 34);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 34);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 34);
    issue(3'b000, 32'hFFFFFFFD, 32'd5, 5'd4, 32'hFFFFFFF1, 34);
    issue(3'b001, 32'hFFFFFFFD, 32'd5, 5'd5, 32'hFFFFFFFF, 34);
    issue(3'b011, 32'h00010000, 32'h00010000, 5'd0, 32'd1, 34);
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 34);
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, 34);
    issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 34);
    issue(3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 34);
    issue(3'b100, 32'd20, 32'hFFFFFFFA, 5'd11, 32'hFFFFFFFD, 34);
    issue(3'b110, 32'd20, 32'hFFFFFFFA, 5'd12, 32'd2, 34);
    issue(3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
    issue(3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 1);
    issue(3'b100, 32'd9, 32'd0, 5'd17, 32'hFFFFFFFF, 1);
    drain();
    wb_ready = 0;
    issue(3'b101, 32'd100, 32'd7, 5'd18, 32'd14, 34);
    for (int i = 0; i < 200 && !wb_valid; i++) @(negedge clk);
    chk("stall_wb_valid", {31'b0, wb_valid}, 32'd1);
    #1 req_valid = 1; req_op = 3'b000; req_rs1 = 32'd1; req_rs2 = 32'd1; req_rd = 5'd3;
    repeat (10) @(negedge clk);
    #1 req_valid = 0; wb_ready = 1;
    @(negedge clk);
    chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_hs_busy", {31'b0, busy}, 32'd0);
    chk("post_hs_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("post_hs_queue", q.size(), 32'd0);
    issue(3'b000, 32'd7, 32'd6, 5'd19, 32'd42, 34);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1 reset = 1; q.delete();
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'b111, 32'd100, 32'd7, 5'd20, 32'd2, 34);
    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
